vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Read-side engine for the 160x120 camera frame buffer. It generates 640x480@60 VGA timing from the 25 MHz pixel clock. It also produces the frame-buffer read address so that each stored pixel is upscaled 4x in both directions, and aligns the synchronous-BRAM read data with the sync and blank outputs. It sits between the dual-port frame buffer's read port and the VGA DAC pins, opposite the camera-side write-address path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 160, stored image width; must equal H_ACTIVE/4
- DATA_W, 12, pixel width (RGB444)
- clk25  in  1  25 MHz pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  display enable; sampled only at frame start
- rd_address  out  17  frame-buffer read address, registered
- rd_data  in  DATA_W  frame-buffer data; valid one clock after rd_address
- pixel  out  DATA_W  RGB to DAC, registered; 0 when blanked or disabled
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank  out  1  high outside the visible region
- frame_done  out  1  one-clock pulse when the last visible address (19199) is issued

## Operation
- hcnt counts 0..H_TOTAL-1, where H_TOTAL = 800. It wraps to 0 and increments vcnt.
- vcnt counts 0..V_TOTAL-1, where V_TOTAL = 525. It wraps to 0.
- active = (hcnt < 640) && (vcnt < 480).
- hs_raw is low for hcnt in [656, 751]. vs_raw is low for vcnt in [490, 491].
- Address = row_base + (hcnt >> 2). The design uses no multiplier.
  - row_base resets to 0.
  - At the end of each line (hcnt = 799) with vcnt[1:0] = 3, row_base += IMG_W.
  - row_base clears to 0 when vcnt wraps.
- rd_address is registered. It takes the address while active and 0 otherwise. Maximum value is 19199, which fits in 17 bits.
- frame_done is registered. It asserts for the position (639, 479), coincident with rd_address = 19199.
- enable is captured into en_frame when hcnt = 0 and vcnt = 0. Mid-frame changes have no effect until the next frame.
- pixel is registered: it takes rd_data when the aligned blank is 0 and en_frame is 1, and 0 otherwise.
- The video timing never stops. enable affects pixel only.

## Timing
- Pipeline stages, with cycle N being the counter position:
  - N: counter position.
  - N+1: rd_address valid.
  - N+2: rd_data valid.
  - N+3: pixel, hsync, vsync and blank valid.
- hs_raw, vs_raw and !active pass through a 3-stage delay so they stay aligned with pixel.
- en_frame is applied at the pixel output stage. The frame boundary therefore lines up with the first visible pixel.
- Reset values: rd_address = 0, pixel = 0, hsync = 1, vsync = 1, blank = 1, frame_done = 0. Counters, row_base, en_frame and all delay stages are 0 or inactive.
- Reset is asynchronous, including mid-frame. Outputs go to their reset values immediately. After release, counting restarts at (0, 0) on the first clock edge.
- The first rd_address = 0 is valid one clock after release, because hcnt = 0 is already active. The first visible pixel appears 3 clocks after release.
- Line period is 800 clocks. Frame period is 420000 clocks.
- The hsync low pulse lasts 96 clocks. The vsync low pulse lasts 1600 clocks.

## Test plan
- Reset and first line: release rst, enable = 1.
  - blank = 1 and hsync = 1 until cycle 3; blank = 0 for cycles 3..642.
  - hsync falls at cycle 659 and rises at cycle 755.
- Address sequence, BRAM model with rd_data = rd_address mod 4096:
  - line 0: rd_address 0,0,0,0,1,1,1,1 … 159 at hcnt 636..639, then 0 during blanking;
  - lines 1..3 repeat 0..159; line 4 starts at 160; line 479 ends at 19199 with frame_done = 1 for exactly one clock.
- Alignment, same BRAM model:
  - pixel at visible position (x, y) equals ((y/4)*160 + x/4) mod 4096;
  - pixel = 0 whenever blank = 1.
- Enable change: drop enable at line 200 of frame k.
  - frame k displays in full;
  - frame k+1 has pixel = 0 throughout, with hsync, vsync and blank identical in timing;
  - raising enable restores pixels starting at frame k+2 (or the first frame after the rise).
- Periodicity: over 3 frames, vsync falling edges are exactly 420000 clocks apart, each low for 1600 clocks; exactly one frame_done pulse per frame.
- Mid-frame reset: assert rst at vcnt = 300, hcnt = 400.
  - outputs go to their reset values without waiting for a clock;
  - after release, the address sequence and sync timing repeat scenario 1 exactly.

Source files
------------

// File: rtl/vga_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_reader_if
//  Description : Frame-buffer read port and VGA DAC signals of the
//                frame reader, grouped as one bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_frame_reader_if #(
   parameter int DATA_W = 12
);
   logic              enable;
   logic [16:0]       rd_address;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] pixel;
   logic              hsync;
   logic              vsync;
   logic              blank;
   logic              frame_done;

   // Reader side: issues addresses, drives the DAC pins
   modport master (
      input  enable, rd_data,
      output rd_address, pixel, hsync, vsync, blank, frame_done
   );

   // Frame buffer / display side
   modport slave (
      output enable, rd_data,
      input  rd_address, pixel, hsync, vsync, blank, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_reader
//  Description : VGA timing generator and 4x-upscaling frame-buffer reader.
//                Counter position -> registered address -> BRAM data ->
//                registered pixel, with sync/blank delayed to match.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_W    = 160,
   parameter int DATA_W   = 12
) (
   input  wire logic          clk25,
   input  wire logic          rst,
   vga_frame_reader_if.master vga
);

   localparam logic [9:0]  c_h_act   = 10'(H_ACTIVE);
   localparam logic [9:0]  c_v_act   = 10'(V_ACTIVE);
   localparam logic [9:0]  c_h_last  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  c_v_last  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  c_hs_first = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  c_hs_last  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  c_vs_first = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  c_vs_last  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]  c_h_vis_last = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  c_v_vis_last = 10'(V_ACTIVE - 1);
   localparam logic [16:0] c_img_w   = 17'(IMG_W);

   logic [9:0]        r_hcnt;
   logic [9:0]        r_vcnt;
   logic [16:0]       r_row_base;
   logic [16:0]       r_rd_address;
   logic              r_frame_done;
   logic [2:0]        r_hs_d;
   logic [2:0]        r_vs_d;
   logic [2:0]        r_blank_d;
   logic              r_en_frame;
   logic [DATA_W-1:0] r_pixel;

   logic              w_active;
   logic              w_hs_raw;
   logic              w_vs_raw;
   logic              w_line_end;
   logic [16:0]       w_addr;

   assign w_active   = (r_hcnt < c_h_act) && (r_vcnt < c_v_act);
   assign w_hs_raw   = !((r_hcnt >= c_hs_first) && (r_hcnt <= c_hs_last));
   assign w_vs_raw   = !((r_vcnt >= c_vs_first) && (r_vcnt <= c_vs_last));
   assign w_line_end = (r_hcnt == c_h_last);
   // Each stored pixel spans four columns, so the column index is hcnt/4
   assign w_addr     = r_row_base + 17'(r_hcnt[9:2]);

   // Raster counters and row base; row base steps once every four lines
   always_ff @(posedge clk25 or negedge rst) begin
      if (!rst) begin
         r_hcnt     <= '0;
         r_vcnt     <= '0;
         r_row_base <= '0;
      end else if (w_line_end) begin
         r_hcnt <= '0;
         if (r_vcnt == c_v_last) begin
            r_vcnt     <= '0;
            r_row_base <= '0;
         end else begin
            r_vcnt <= r_vcnt + 10'd1;
            if (r_vcnt[1:0] == 2'd3) begin
               r_row_base <= r_row_base + c_img_w;
            end
         end
      end else begin
         r_hcnt <= r_hcnt + 10'd1;
      end
   end

   // Address stage: read address and end-of-image marker for the same position
   always_ff @(posedge clk25 or negedge rst) begin
      if (!rst) begin
         r_rd_address <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_rd_address <= w_active ? w_addr : 17'd0;
         r_frame_done <= (r_hcnt == c_h_vis_last) && (r_vcnt == c_v_vis_last);
      end
   end

   // Three-stage delay keeps sync/blank aligned with the registered pixel
   always_ff @(posedge clk25 or negedge rst) begin
      if (!rst) begin
         r_hs_d    <= 3'b111;
         r_vs_d    <= 3'b111;
         r_blank_d <= 3'b111;
      end else begin
         r_hs_d    <= {r_hs_d[1:0], w_hs_raw};
         r_vs_d    <= {r_vs_d[1:0], w_vs_raw};
         r_blank_d <= {r_blank_d[1:0], !w_active};
      end
   end

   // Enable is latched only at the frame origin so a frame is never split
   always_ff @(posedge clk25 or negedge rst) begin
      if (!rst) begin
         r_en_frame <= 1'b0;
      end else if ((r_hcnt == 10'd0) && (r_vcnt == 10'd0)) begin
         r_en_frame <= vga.enable;
      end
   end

   // Output pixel: BRAM data when visible and enabled, black otherwise
   always_ff @(posedge clk25 or negedge rst) begin
      if (!rst) begin
         r_pixel <= '0;
      end else begin
         r_pixel <= (!r_blank_d[1] && r_en_frame) ? vga.rd_data : '0;
      end
   end

   assign vga.rd_address = r_rd_address;
   assign vga.frame_done = r_frame_done;
   assign vga.pixel      = r_pixel;
   assign vga.hsync      = r_hs_d[2];
   assign vga.vsync      = r_vs_d[2];
   assign vga.blank      = r_blank_d[2];

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_frame_reader
//  Description : Self-checking bench for vga_frame_reader using a reduced
//                raster, a randomly filled BRAM and an arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_frame_reader;

   localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
   localparam int VA = 16, VFP = 3, VS = 2, VBP = 3;
   localparam int IMGW = HA / 4;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int F  = HT * VT;
   localparam int LASTPOS = (VA - 1) * HT + (HA - 1);

   logic clk25 = 1'b0;
   logic rst   = 1'b0;

   vga_frame_reader_if #(.DATA_W(12)) vif ();

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .IMG_W(IMGW), .DATA_W(12)
   ) dut (
      .clk25 (clk25),
      .rst   (rst),
      .vga   (vif)
   );

   always #5 clk25 = ~clk25;

   logic [11:0] mem [0:255];
   bit          en_edge [0:8191];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cur_cycle = 0;

   // Synchronous BRAM read port model
   always @(posedge clk25) vif.rd_data <= mem[vif.rd_address[7:0]];

   function automatic bit m_active(int k);
      int p = k % F;
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic int m_addr(int k);
      int p = k % F;
      return m_active(k) ? ((p / HT) / 4) * IMGW + (p % HT) / 4 : 0;
   endfunction

   function automatic bit m_hsync(int k);
      int h = (k % F) % HT;
      return !(h >= HA + HFP && h < HA + HFP + HS);
   endfunction

   function automatic bit m_vsync(int k);
      int v = (k % F) / HT;
      return !(v >= VA + VFP && v < VA + VFP + VS);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cur_cycle, obs, exp);
   endtask

   task automatic chk_reset_values();
      chk("rst_rd_address", 32'(vif.rd_address), 0);
      chk("rst_pixel",      32'(vif.pixel), 0);
      chk("rst_hsync",      32'(vif.hsync), 1);
      chk("rst_vsync",      32'(vif.vsync), 1);
      chk("rst_blank",      32'(vif.blank), 1);
      chk("rst_frame_done", 32'(vif.frame_done), 0);
   endtask

   // Compare all outputs at cycle c (c edges after reset release)
   task automatic chk_cycle(input int c);
      int k1 = c - 1;
      int k3 = c - 3;
      int e_addr = (c >= 1) ? m_addr(k1) : 0;
      int e_fd   = (c >= 1 && (k1 % F) == LASTPOS) ? 1 : 0;
      int e_hs   = (c >= 3) ? int'(m_hsync(k3)) : 1;
      int e_vs   = (c >= 3) ? int'(m_vsync(k3)) : 1;
      int e_bl   = (c >= 3) ? int'(!m_active(k3)) : 1;
      int e_pix  = 0;
      if (c >= 3 && m_active(k3) && en_edge[(k3 / F) * F + 1])
         e_pix = int'(mem[m_addr(k3)]);
      cur_cycle = c;
      chk("rd_address", 32'(vif.rd_address), e_addr);
      chk("frame_done", 32'(vif.frame_done), e_fd);
      chk("hsync",      32'(vif.hsync), e_hs);
      chk("vsync",      32'(vif.vsync), e_vs);
      chk("blank",      32'(vif.blank), e_bl);
      chk("pixel",      32'(vif.pixel), e_pix);
   endtask

   // Run ncyc clocks after a release; mode 1 applies the enable schedule
   task automatic run_phase(input int ncyc, input int mode);
      int  last_fall = -1;
      int  last_fd   = -1;
      int  fd_cnt    = 0;
      int  fd_exp;
      bit  prev_vs   = 1'b1;
      bit  nxt;
      for (int c = 0; c <= ncyc; c++) begin
         if (c > 0) @(posedge clk25);
         #1;
         chk_cycle(c);
         if (prev_vs && !vif.vsync) begin
            if (last_fall >= 0) chk("vsync_period", 32'(c - last_fall), F);
            last_fall = c;
         end
         if (!prev_vs && vif.vsync) chk("vsync_low_len", 32'(c - last_fall), VS * HT);
         prev_vs = vif.vsync;
         if (vif.frame_done) begin
            if (last_fd >= 0) chk("frame_done_period", 32'(c - last_fd), F);
            last_fd = c;
            fd_cnt++;
         end
         nxt = vif.enable;
         if (mode == 0) nxt = 1'b1;
         else if (c + 1 < F + 7 * HT) nxt = 1'b1;
         else if (c + 1 < 2 * F + 600) nxt = 1'b0;
         else if (c + 1 < 3 * F) nxt = 1'b1;
         else if ($urandom_range(0, 299) == 0) nxt = !vif.enable;
         vif.enable = nxt;
         en_edge[c + 1] = nxt;
      end
      fd_exp = (ncyc - 1 >= LASTPOS) ? (ncyc - 1 - LASTPOS) / F + 1 : 0;
      chk("frame_done_count", 32'(fd_cnt), fd_exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(1, 4095));
      vif.enable = 1'b0;
      rst = 1'b0;
      #23;
      chk_reset_values();

      // Scenario: release, full frames, enable drop/restore, random toggles
      @(negedge clk25);
      rst = 1'b1;
      run_phase(4 * F + 10 * HT + 20, 1);

      // Mid-frame reset: outputs must return to reset values without a clock
      #2;
      rst = 1'b0;
      #1;
      chk_reset_values();
      repeat (3) @(posedge clk25);
      #1;
      chk_reset_values();

      // After release the first-frame behaviour must repeat exactly
      @(negedge clk25);
      rst = 1'b1;
      run_phase(2 * F + 10, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
